// File: rtl/fxp_pkg.sv
// Shared types for the fixed-point ALU: op encoding, FSM states and nzvc bit positions.
package fxp_pkg;

    typedef enum logic [1:0] {
        FXP_ADD = 2'd0,
        FXP_SUB = 2'd1,
        FXP_MUL = 2'd2,
        FXP_RSV = 2'd3
    } fxp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } fxp_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/fxp_seq_mult.sv
// Unsigned shift-add multiplier: one partial product per cycle over WIDTH cycles.
// done pulses during the last step; product carries the final sum in that same cycle.
module fxp_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    assign done    = (cnt_q == CW'(1));
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/fxp_alu_pipe.sv
// Fixed-point ADD/SUB (1 cycle) and MUL (WIDTH+1 cycles) with nzvc flags and a valid/ready handshake.
// Define FXP_ALU_SAT_EN to clamp overflowed results; otherwise they wrap.
module fxp_alu_pipe
    import fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] result,
    output logic [3:0]              nzvc
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    fxp_state_e state_q, state_d;
    fxp_op_e    op_in, op_q, op_d;
    logic       mul_neg_q, mul_neg_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic [3:0] nzvc_q, nzvc_d;

    logic accept, mul_start, mul_done, mul_fin;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    product;

    logic [WIDTH:0]          as_ext;
    logic                    as_v, as_c;
    logic signed [WIDTH-1:0] as_res;
    logic [PW-1:0]           mul_shift;
    logic [WIDTH-1:0]        mul_low;
    logic                    mul_v;
    logic signed [WIDTH-1:0] mul_res;

    function automatic logic [3:0] make_flags(input logic signed [WIDTH-1:0] r,
                                              input logic v, input logic c);
        make_flags         = '0;
        make_flags[FLAG_N] = r[WIDTH-1];
        make_flags[FLAG_Z] = (r == '0);
        make_flags[FLAG_V] = v;
        make_flags[FLAG_C] = c;
    endfunction

`ifdef FXP_ALU_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign op_in = fxp_op_e'(op);

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end

    fxp_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (mul_done),
        .product (product)
    );

    // Add/sub evaluated straight off the accepted operands; on overflow the true sign is a's.
    always_comb begin
        if (op_in == FXP_SUB) begin
            as_ext = {1'b0, a} - {1'b0, b};
            as_c   = ~as_ext[WIDTH];
            as_v   = (a[WIDTH-1] != b[WIDTH-1]) && (as_ext[WIDTH-1] != a[WIDTH-1]);
        end else begin
            as_ext = {1'b0, a} + {1'b0, b};
            as_c   = as_ext[WIDTH];
            as_v   = (a[WIDTH-1] == b[WIDTH-1]) && (as_ext[WIDTH-1] != a[WIDTH-1]);
        end
        as_res = as_ext[WIDTH-1:0];
`ifdef FXP_ALU_SAT_EN
        if (as_v) begin
            as_res = sat_limit(a[WIDTH-1]);
        end
`endif
    end

    // A negative product may reach exactly -2^(WIDTH-1) and still fit.
    always_comb begin
        mul_shift = product >> FRAC;
        mul_low   = mul_shift[WIDTH-1:0];
        mul_v     = mul_neg_q ? (mul_shift > NEG_LIM) : (mul_shift[PW-1:WIDTH-1] != '0);
        mul_res   = mul_neg_q ? -mul_low : mul_low;
`ifdef FXP_ALU_SAT_EN
        if (mul_v) begin
            mul_res = sat_limit(mul_neg_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = (op_in == FXP_MUL) ? ST_MUL_BUSY : ST_DONE;
            ST_MUL_BUSY: if (mul_fin) state_d = ST_DONE;
            ST_DONE:     if (out_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE) && !rst;
        accept    = in_valid && in_ready;
        mul_start = accept && (op_in == FXP_MUL);
        mul_fin   = (state_q == ST_MUL_BUSY) && (op_q == FXP_MUL) && mul_done;
    end

    always_comb begin
        op_d      = op_q;
        mul_neg_d = mul_neg_q;
        result_d  = result_q;
        nzvc_d    = nzvc_q;
        if (accept) begin
            op_d      = op_in;
            mul_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            if (op_in != FXP_MUL) begin
                result_d = as_res;
                nzvc_d   = make_flags(as_res, as_v, as_c);
            end
        end
        if (mul_fin) begin
            result_d = mul_res;
            nzvc_d   = make_flags(mul_res, mul_v, 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            nzvc_q   <= '0;
        end else begin
            result_q <= result_d;
            nzvc_q   <= nzvc_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        mul_neg_q <= mul_neg_d;
    end

    assign result = result_q;
    assign nzvc   = nzvc_q;

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Directed bench for fxp_alu_pipe at WIDTH=16, FRAC=8; expectations are hand-computed.
module tb_fxp_alu_pipe;

`ifdef FXP_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  nzvc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fxp_alu_pipe #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nzvc      (nzvc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op, then waits (bounded) for out_valid and checks the latency.
    task automatic issue_wait(input string tag, input logic [1:0] o,
                              input logic [15:0] av, input logic [15:0] bv, input int elat);
        int lat;
        bit got;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'h5A5A; b = 16'hA5A5; op = 2'd1;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!got) lat = -1;
        check({tag, ".latency"}, 32'(lat), 32'(elat));
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er, input logic [3:0] ef,
                          input int elat);
        issue_wait(tag, o, av, bv, elat);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".nzvc"}, 32'(nzvc), 32'(ef));
        release_res(tag);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.nzvc", 32'(nzvc), 32'd0);
        rst = 1'b0;
        #1;
        check("reset.release_ready", 32'(in_ready), 32'd1);

        run_op("mul_1p5x2",    2'd2, 16'h0180, 16'h0200, 16'h0300, 4'b0000, 17);
        run_op("mul_m1p5x2",   2'd2, 16'hFE80, 16'h0200, 16'hFD00, 4'b1000, 17);
        run_op("mul_ovf",      2'd2, 16'h4000, 16'h0400, SAT ? 16'h7FFF : 16'h0000,
               SAT ? 4'b0010 : 4'b0110, 17);
        run_op("mul_minneg",   2'd2, 16'h8000, 16'h0100, 16'h8000, 4'b1000, 17);
        run_op("mul_min_sq",   2'd2, 16'h8000, 16'h8000, SAT ? 16'h7FFF : 16'h0000,
               SAT ? 4'b0010 : 4'b0110, 17);
        run_op("mul_neg_sq",   2'd2, 16'hFF00, 16'hFF00, 16'h0100, 4'b0000, 17);
        run_op("mul_trunc",    2'd2, 16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 17);
        run_op("add_ovf",      2'd0, 16'h7F00, 16'h0200, SAT ? 16'h7FFF : 16'h8100,
               SAT ? 4'b0010 : 4'b1010, 1);
        run_op("sub_zero",     2'd1, 16'h0100, 16'h0100, 16'h0000, 4'b0101, 1);
        run_op("sub_borrow",   2'd1, 16'h0100, 16'h0200, 16'hFF00, 4'b1000, 1);
        run_op("add_carry",    2'd0, 16'hFF00, 16'h0100, 16'h0000, 4'b0101, 1);
        run_op("op3_add",      2'd3, 16'h0100, 16'h0100, 16'h0200, 4'b0000, 1);
        run_op("sub_ovf",      2'd1, 16'h8000, 16'h0100, SAT ? 16'h8000 : 16'h7F00,
               SAT ? 4'b1011 : 4'b0011, 1);

        // Backpressure: output must hold while new requests are presented.
        issue_wait("hold", 2'd0, 16'h0300, 16'h0100, 1);
        check("hold.result0", 32'(result), 32'h0400);
        check("hold.nzvc0", 32'(nzvc), 32'h0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 2'd1; a = 16'h7777; b = 16'h1111;
            @(posedge clk);
            @(negedge clk);
            check("hold.result", 32'(result), 32'h0400);
            check("hold.nzvc", 32'(nzvc), 32'h0);
            check("hold.in_ready", 32'(in_ready), 32'd0);
            check("hold.out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_res("hold");
        check("hold.after_result", 32'(result), 32'h0400);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        in_valid = 1'b1; op = 2'd2; a = 16'h0180; b = 16'h0200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd0);
        check("abort.result", 32'(result), 32'd0);
        check("abort.nzvc", 32'(nzvc), 32'd0);
        rst = 1'b0;
        #1;
        check("abort.release_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_valid", 32'(seen), 32'd0);
        run_op("post_abort_add", 2'd0, 16'h0100, 16'h0100, 16'h0200, 4'b0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
